// File: rtl/pwm_sample_sequencer.sv
// Sample sequencer feeding a PWM DataIn: buffers upstream samples in a small FIFO and
// releases one per PWM period, with priming, underflow counting and a ramp-to-zero mute.
module pwm_sample_sequencer #(
    parameter int DATA_WIDTH    = 12,
    parameter int COUNTER_WIDTH = 10,
    parameter int FIFO_DEPTH    = 4,
    parameter int PRIME_LEVEL   = 2,
    parameter int RAMP_STEP     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] pwm_data,
    output logic                  period_tick,
    output logic                  busy,
    output logic [7:0]            underflow_cnt,
    output logic [1:0]            dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]         DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]         PRIME_CNT = CW'(PRIME_LEVEL);
    localparam logic [DATA_WIDTH:0]   STEP_EXT  = (DATA_WIDTH + 1)'(RAMP_STEP);
    localparam logic [DATA_WIDTH-1:0] STEP      = DATA_WIDTH'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        MUTE  = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [COUNTER_WIDTH-1:0] per_cnt;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    push, pop, flush, underflow;
    logic [DATA_WIDTH-1:0]   pwm_nxt;
    logic [DATA_WIDTH:0]     pwm_ext, pwm_mag;
    logic                    ramp_done;

    assign period_tick = (per_cnt == {COUNTER_WIDTH{1'b1}});
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    // Upstream handshake: a sample transfers on a clk edge where s_valid and s_ready are
    // both 1; s_data must be stable while s_valid is 1, and s_ready never depends on s_valid.
    assign s_ready = rstn && enable && (count < DEPTH_CNT) && (state != MUTE);
    assign push    = s_valid && s_ready;

    // Magnitude is taken one bit wider so the most negative code does not wrap.
    assign pwm_ext   = {pwm_data[DATA_WIDTH-1], pwm_data};
    assign pwm_mag   = pwm_ext[DATA_WIDTH] ? (~pwm_ext + (DATA_WIDTH + 1)'(1)) : pwm_ext;
    assign ramp_done = (pwm_mag <= STEP_EXT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = PRIME;
            PRIME: begin
                if (!enable)                                 state_nxt = MUTE;
                else if (period_tick && count >= PRIME_CNT)  state_nxt = RUN;
            end
            RUN:     if (!enable) state_nxt = MUTE;
            MUTE:    if (period_tick && ramp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Leaving for MUTE takes priority over a pop on the same tick.
    always_comb begin
        pop       = 1'b0;
        flush     = 1'b0;
        underflow = 1'b0;
        pwm_nxt   = pwm_data;
        case (state)
            PRIME: begin
                if (!enable)                                flush = 1'b1;
                else if (period_tick && count >= PRIME_CNT) pop   = 1'b1;
            end
            RUN: begin
                if (!enable)                        flush     = 1'b1;
                else if (period_tick && count != '0) pop       = 1'b1;
                else if (period_tick)                underflow = 1'b1;
            end
            MUTE: begin
                if (period_tick) begin
                    if (ramp_done)                    pwm_nxt = '0;
                    else if (pwm_data[DATA_WIDTH-1])  pwm_nxt = pwm_data + STEP;
                    else                              pwm_nxt = pwm_data - STEP;
                end
            end
            default: ;
        endcase
        if (pop) pwm_nxt = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            per_cnt       <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pwm_data      <= '0;
            underflow_cnt <= '0;
        end else begin
            per_cnt  <= per_cnt + COUNTER_WIDTH'(1);
            pwm_data <= pwm_nxt;
            if (underflow && underflow_cnt != 8'hFF)
                underflow_cnt <= underflow_cnt + 8'd1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Bench for pwm_sample_sequencer: directed scenarios plus random traffic, checked by a
// queue-based reference model with a scoreboard popped at every PWM period boundary.
module tb_pwm_sample_sequencer;

    localparam int DW     = 12;
    localparam int CNTW   = 4;
    localparam int PERIOD = 16;
    localparam int DEPTH  = 4;
    localparam int PLEVEL = 2;
    localparam int STEP   = 8;
    localparam int W      = 21;
    localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_MUTE = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] pwm_data;
    logic          period_tick;
    logic          busy;
    logic [7:0]    underflow_cnt;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           fq[$];
    int           mmode, mpwm, muf, mcnt;
    bit           pending;

    pwm_sample_sequencer #(
        .DATA_WIDTH(DW), .COUNTER_WIDTH(CNTW), .FIFO_DEPTH(DEPTH),
        .PRIME_LEVEL(PLEVEL), .RAMP_STEP(STEP)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .pwm_data(pwm_data), .period_tick(period_tick), .busy(busy),
        .underflow_cnt(underflow_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // reference model: evaluates the upcoming edge from stable inputs
    always @(negedge clk) begin
        bit tick, rdy, acc;
        int mag;
        if (!rstn) begin
            fq.delete();
            exp_q.delete();
            mmode = M_IDLE; mpwm = 0; muf = 0; mcnt = 0;
        end else begin
            tick = (mcnt == PERIOD - 1);
            rdy  = enable && (fq.size() < DEPTH) && (mmode != M_MUTE);
            check("s_ready", 32'(s_ready), 32'(rdy));
            check("period_tick", 32'(period_tick), 32'(tick));
            check("busy", 32'(busy), 32'(mmode != M_IDLE));
            check("state", 32'(dbg_state), 32'(mmode));
            acc = s_valid && rdy;
            case (mmode)
                M_IDLE: if (enable) mmode = M_PRIME;
                M_PRIME: begin
                    if (!enable) begin fq.delete(); mmode = M_MUTE; end
                    else if (tick && fq.size() >= PLEVEL) begin
                        mpwm = fq.pop_front(); mmode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (!enable) begin fq.delete(); mmode = M_MUTE; end
                    else if (tick) begin
                        if (fq.size() > 0) mpwm = fq.pop_front();
                        else if (muf < 255) muf = muf + 1;
                    end
                end
                default: begin
                    if (tick) begin
                        mag = (mpwm < 0) ? -mpwm : mpwm;
                        if (mag <= STEP) begin mpwm = 0; mmode = M_IDLE; end
                        else mpwm = (mpwm < 0) ? mpwm + STEP : mpwm - STEP;
                    end
                end
            endcase
            if (acc) fq.push_back(int'($signed(s_data)));
            if (tick) exp_q.push_back({DW'(mpwm), 8'(muf), 1'(mmode != M_IDLE)});
            mcnt = (mcnt + 1) % PERIOD;
        end
    end

    // scoreboard monitor: one expected entry per period boundary
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rstn) pending = 1'b0;
        else begin
            if (pending) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty at %0t: got output with no expected entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_out{pwm,ufl,busy}", 32'({pwm_data, underflow_cnt, busy}), 32'(e));
                end
            end
            pending = period_tick;
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        int n = 0;
        s_valid = 1'b1;
        s_data  = v;
        #1;
        while (!s_ready && n < 64) begin cycle(); n++; end
        if (!s_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout at %0t: s_ready stuck 0 expected 1", $time);
        end
        cycle();
        s_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!period_tick && n < 40) begin cycle(); n++; end
        if (!period_tick) begin
            checks++; errors++;
            $display("FAIL wait_tick at %0t: period_tick 0 expected 1", $time);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        int n = 0;
        while (dbg_state != st && n < budget) begin cycle(); n++; end
        check("wait_state", 32'(dbg_state), 32'(st));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_pwm"}, 32'(pwm_data), 32'd0);
        check({tag, "_tick"}, 32'(period_tick), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ufl"}, 32'(underflow_cnt), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(M_IDLE));
    endtask

    initial begin
        int acc;
        logic [DW-1:0] a, b;
        rstn = 1'b0; enable = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        // priming and ordered playback
        push(12'd5); push(12'd6); push(12'd7);
        wait_state(2'(M_RUN), 40);
        check("first_sample", 32'(pwm_data), 32'd5);
        wait_tick(); cycle();
        check("second_sample", 32'(pwm_data), 32'd6);
        wait_tick(); cycle();
        check("third_sample", 32'(pwm_data), 32'd7);

        // underflow and saturation
        repeat (3) begin wait_tick(); cycle(); end
        check("ufl_3", 32'(underflow_cnt), 32'd3);
        check("ufl_hold", 32'(pwm_data), 32'd7);
        repeat (300 * PERIOD) cycle();
        check("ufl_sat", 32'(underflow_cnt), 32'd255);

        // fill without ticks, then push+pop at count 2
        wait_tick(); cycle();
        acc = 0; s_valid = 1'b1;
        repeat (8) begin
            s_data = DW'($urandom_range(0, 4095)); #1;
            if (s_ready) acc++;
            cycle();
        end
        s_valid = 1'b0;
        check("fill_accepts", 32'(acc), 32'd4);
        wait_tick(); cycle();
        wait_tick(); cycle();
        wait_tick();
        acc = 0; s_valid = 1'b1;
        repeat (6) begin
            s_data = DW'($urandom_range(0, 4095)); #1;
            if (s_ready) acc++;
            cycle();
        end
        s_valid = 1'b0;
        check("pushpop_accepts", 32'(acc), 32'd3);

        // mute ramp from 20
        enable = 1'b0;
        wait_state(2'(M_IDLE), 6000);
        enable = 1'b1;
        push(12'd20); push(12'd20);
        wait_state(2'(M_RUN), 40);
        check("pwm_20", 32'(pwm_data), 32'd20);
        enable = 1'b0;
        repeat (4 * PERIOD) cycle();
        check("mute20_pwm", 32'(pwm_data), 32'd0);
        check("mute20_busy", 32'(busy), 32'd0);

        // most negative code, enable re-asserted during ramp
        enable = 1'b1;
        push(12'h800); push(12'h000);
        wait_state(2'(M_RUN), 40);
        check("pwm_min", 32'(pwm_data), 32'h800);
        enable = 1'b0;
        cycle();
        wait_tick(); cycle();
        check("ramp_min", 32'(pwm_data), 32'h808);
        enable = 1'b1;
        wait_state(2'(M_IDLE), 300 * PERIOD);
        cycle();
        check("reenable_prime", 32'(dbg_state), 32'(M_PRIME));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = ($urandom_range(0, 9) == 0) ? 12'h800 : DW'($urandom_range(0, 4095));
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            cycle();
        end
        s_valid = 1'b0;

        // asynchronous reset in RUN with three buffered samples
        enable = 1'b0;
        wait_state(2'(M_IDLE), 6000);
        enable = 1'b1;
        a = DW'($urandom_range(1, 2047));
        b = DW'($urandom_range(1, 2047));
        push(a); push(b);
        wait_state(2'(M_RUN), 40);
        check("pre_reset_pwm", 32'(pwm_data), 32'(a));
        push(DW'($urandom_range(1, 2047)));
        push(DW'($urandom_range(1, 2047)));
        #2 rstn = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3 * PERIOD) cycle();
        check("post_reset_pwm", 32'(pwm_data), 32'd0);
        check("post_reset_state", 32'(dbg_state), 32'(M_PRIME));
        repeat (5) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
